// File: rtl/decoder_pkg.sv
// Shared decode-stage types: register index, ALU opcode and hazard controller state.
// Every module in the issue path imports this package.
package decoder_pkg;

    localparam int REG_W    = 4;
    localparam int NUM_REGS = 1 << REG_W;
    localparam int INFL_W   = 4;

    typedef logic [REG_W-1:0] reg_t;

    typedef enum logic [2:0] {
        op_none = 3'd0,
        op_add  = 3'd1,
        op_sub  = 3'd2,
        op_and  = 3'd3,
        op_or   = 3'd4,
        op_xor  = 3'd5
    } alu_opcode_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    // op_none is a bubble: it reads no sources and writes no destination
    function automatic logic uses_regs(alu_opcode_t op);
        return op != op_none;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: one pending bit per architectural register plus a count
// of issued instructions still awaiting writeback.
module hazard_scoreboard
    import decoder_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                set_valid,
    input  reg_t                set_reg,
    input  logic                wb_valid,
    input  reg_t                wb_reg,
    output logic [NUM_REGS-1:0] pending,
    output logic [INFL_W-1:0]   inflight,
    output logic                full,
    output logic                wb_illegal
);

    logic              clr_valid;
    logic [INFL_W-1:0] inflight_next;

    assign clr_valid  = wb_valid && pending[wb_reg];
    assign wb_illegal = wb_valid && !pending[wb_reg];
    assign full       = (inflight == INFL_W'(MAX_INFLIGHT));

    // A simultaneous set and clear leaves the count unchanged
    always_comb begin
        inflight_next = inflight;
        if (set_valid && !clr_valid) begin
            inflight_next = inflight + INFL_W'(1);
        end else if (!set_valid && clr_valid) begin
            inflight_next = inflight - INFL_W'(1);
        end
    end

    // NOTE: the pending vector is plain flops, not a RAM, so it is safe and
    // required to reset it; the later non-blocking write lets set beat clear.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            pending  <= '0;
            inflight <= '0;
        end else begin
            if (clr_valid) pending[wb_reg]  <= 1'b0;
            if (set_valid) pending[set_reg] <= 1'b1;
            inflight <= inflight_next;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue-stage hazard controller: RUN/STALL/DRAIN FSM, single-entry issue register
// and saturating stall counter around the register scoreboard.
module hazard_ctrl
    import decoder_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   dec_valid_i,
    input  alu_opcode_t            dec_opcode_i,
    input  reg_t                   dec_src1_i,
    input  reg_t                   dec_src2_i,
    input  reg_t                   dec_dst_i,
    output logic                   dec_ready_o,
    output logic                   ex_valid_o,
    output alu_opcode_t            ex_opcode_o,
    output reg_t                   ex_dst_o,
    input  logic                   ex_ready_i,
    input  logic                   wb_valid_i,
    input  reg_t                   wb_dst_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output ctrl_state_t            state_o,
    output logic                   wb_err_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    ctrl_state_t         state;
    ctrl_state_t         state_next;
    logic [NUM_REGS-1:0] pending;
    logic [INFL_W-1:0]   inflight;
    logic                full;
    logic                wb_illegal;
    logic                hazard;
    logic                slot_free;
    logic                issue;

    hazard_scoreboard #(
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_scoreboard (
        .clk       (clk),
        .arstn     (arstn),
        .set_valid (issue && uses_regs(dec_opcode_i)),
        .set_reg   (dec_dst_i),
        .wb_valid  (wb_valid_i),
        .wb_reg    (wb_dst_i),
        .pending   (pending),
        .inflight  (inflight),
        .full      (full),
        .wb_illegal(wb_illegal)
    );

    // Registered scoreboard only: a writeback in this cycle does not unblock this cycle
    assign hazard = uses_regs(dec_opcode_i) &&
                    (pending[dec_src1_i] || pending[dec_src2_i] || pending[dec_dst_i]);

    assign slot_free = !ex_valid_o || ex_ready_i;
    assign issue     = dec_valid_i && dec_ready_o;
    assign stall_o   = dec_valid_i && !dec_ready_o;
    assign state_o   = state;

    always_comb begin
        state_next  = state;
        dec_ready_o = 1'b0;
        if (state != DRAIN) begin
            dec_ready_o = !hazard && !full && !flush_i && slot_free;
        end
        unique case (state)
            RUN:     if (dec_valid_i && (hazard || full))    state_next = STALL;
            STALL:   if (!(dec_valid_i && (hazard || full))) state_next = RUN;
            DRAIN:   if (inflight == '0)                     state_next = RUN;
            default: state_next = RUN;
        endcase
        if (flush_i) state_next = DRAIN;
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A flushed instruction keeps its scoreboard entry; only the issue slot is dropped
    always_ff @(posedge clk) begin
        if (!arstn) begin
            ex_valid_o  <= 1'b0;
            ex_opcode_o <= op_none;
            ex_dst_o    <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (issue) begin
            ex_valid_o  <= 1'b1;
            ex_opcode_o <= dec_opcode_i;
            ex_dst_o    <= dec_dst_i;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            wb_err_o    <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (wb_illegal) wb_err_o <= 1'b1;
            if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
    import decoder_pkg::*;

    localparam int MAX_INF  = 4;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int N_RANDOM = 3000;

    logic             clk = 1'b0;
    logic             arstn;
    logic             dec_valid;
    alu_opcode_t      dec_op;
    reg_t             src1, src2, dst;
    logic             dec_ready;
    logic             ex_valid;
    alu_opcode_t      ex_op;
    reg_t             ex_dst;
    logic             ex_ready;
    logic             wb_valid;
    reg_t             wb_dst;
    logic             flush;
    logic             stall;
    ctrl_state_t      state;
    logic             wb_err;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (state: 0 RUN, 1 STALL, 2 DRAIN)
    bit m_pend [NUM_REGS];
    int m_infl, m_state, m_exop, m_exd, m_cnt;
    bit m_exv, m_err;

    hazard_ctrl #(.MAX_INFLIGHT(MAX_INF), .STALL_CNT_W(CNT_W)) dut (
        .clk         (clk),
        .arstn       (arstn),
        .dec_valid_i (dec_valid),
        .dec_opcode_i(dec_op),
        .dec_src1_i  (src1),
        .dec_src2_i  (src2),
        .dec_dst_i   (dst),
        .dec_ready_o (dec_ready),
        .ex_valid_o  (ex_valid),
        .ex_opcode_o (ex_op),
        .ex_dst_o    (ex_dst),
        .ex_ready_i  (ex_ready),
        .wb_valid_i  (wb_valid),
        .wb_dst_i    (wb_dst),
        .flush_i     (flush),
        .stall_o     (stall),
        .state_o     (state),
        .wb_err_o    (wb_err),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit m_hazard();
        if (dec_op == op_none) return 1'b0;
        return m_pend[src1] || m_pend[src2] || m_pend[dst];
    endfunction

    function automatic bit m_ready();
        return (m_state != 2) && !m_hazard() && (m_infl != MAX_INF) && !flush &&
               (!m_exv || ex_ready);
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_infl = 0; m_state = 0; m_exv = 0; m_exop = 0; m_exd = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_update();
        bit rdy, iss, blocked;
        int ns;
        if (!arstn) begin
            model_reset();
            return;
        end
        rdy     = m_ready();
        iss     = dec_valid && rdy;
        blocked = dec_valid && (m_hazard() || m_infl == MAX_INF);
        if (dec_valid && !rdy && m_cnt != CNT_MAX) m_cnt++;
        ns = m_state;
        if (flush)                          ns = 2;
        else if (m_state == 0 && blocked)   ns = 1;
        else if (m_state == 1 && !blocked)  ns = 0;
        else if (m_state == 2 && m_infl == 0) ns = 0;
        if (flush) m_exv = 0;
        else if (iss) begin m_exv = 1; m_exop = int'(dec_op); m_exd = int'(dst); end
        else if (ex_ready) m_exv = 0;
        if (wb_valid) begin
            if (m_pend[wb_dst]) begin m_pend[wb_dst] = 0; m_infl--; end
            else m_err = 1;
        end
        if (iss && dec_op != op_none) begin m_pend[dst] = 1; m_infl++; end
        m_state = ns;
    endtask

    task automatic compare_all();
        bit r;
        r = m_ready();
        check("dec_ready", dec_ready, r);
        check("stall", stall, dec_valid && !r);
        check("ex_valid", ex_valid, m_exv);
        check("ex_opcode", ex_op, m_exop);
        check("ex_dst", ex_dst, m_exd);
        check("state", state, m_state);
        check("wb_err", wb_err, m_err);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    // Compare mid-cycle, advance model with the edge, then leave room to drive
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        arstn = 1; dec_valid = 0; dec_op = op_none; src1 = 0; src2 = 0; dst = 0;
        ex_ready = 1; wb_valid = 0; wb_dst = 0; flush = 0;
    endtask

    task automatic offer(input alu_opcode_t op, input int d, input int s1, input int s2);
        dec_valid = 1; dec_op = op; dst = reg_t'(d); src1 = reg_t'(s1); src2 = reg_t'(s2);
    endtask

    task automatic do_reset();
        idle(); arstn = 0; tick(); tick(); arstn = 1;
    endtask

    initial begin
        int c0;
        int q[$];
        idle();
        arstn = 0;
        @(posedge clk); model_update(); #1;
        tick();
        arstn = 1;
        check("rst_state", state, RUN);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // RAW: second add reads r1 while it is pending
        offer(op_add, 1, 2, 3); tick();
        offer(op_add, 4, 1, 5); tick();
        check("raw_stall", stall, 1);
        check("raw_state", state, STALL);
        tick(); tick();
        wb_valid = 1; wb_dst = 1; tick(); wb_valid = 0;
        check("raw_release", dec_ready, 1);
        tick(); dec_valid = 0;
        check("raw_issued", ex_dst, 4);
        tick();
        wb_valid = 1; wb_dst = 4; tick(); wb_valid = 0;

        // WAW on r1
        offer(op_add, 1, 6, 7); tick();
        offer(op_add, 1, 2, 3); tick(); tick();
        check("waw_stall", stall, 1);
        wb_valid = 1; wb_dst = 1; tick(); wb_valid = 0;
        tick(); dec_valid = 0; tick();
        wb_valid = 1; wb_dst = 1; tick(); wb_valid = 0;

        // Inflight limit
        for (int i = 1; i <= 4; i++) begin offer(op_add, i, 8, 9); tick(); end
        offer(op_add, 5, 8, 9); tick(); tick();
        check("full_stall", stall, 1);
        wb_valid = 1; wb_dst = 2; tick(); wb_valid = 0;
        tick(); dec_valid = 0;
        check("full_issued", ex_dst, 5);
        for (int i = 1; i <= 5; i++) if (i != 2) begin wb_valid = 1; wb_dst = reg_t'(i); tick(); end
        wb_valid = 0; tick();

        // Back-pressure from execute
        ex_ready = 0; offer(op_sub, 10, 11, 12); tick();
        offer(op_and, 13, 11, 12);
        c0 = int'(stall_cnt);
        tick(); tick(); tick();
        check("bp_cnt_delta", int'(stall_cnt) - c0, 3);
        check("bp_ex_dst", ex_dst, 10);
        ex_ready = 1; tick(); dec_valid = 0; tick();
        wb_valid = 1; wb_dst = 10; tick(); wb_dst = 13; tick(); wb_valid = 0;

        // Flush with two inflight, then drain
        offer(op_or, 3, 0, 0); tick(); offer(op_xor, 6, 0, 0); tick();
        offer(op_add, 7, 0, 0); flush = 1; tick(); flush = 0;
        check("flush_state", state, DRAIN);
        tick();
        wb_valid = 1; wb_dst = 3; tick(); wb_dst = 6; tick(); wb_valid = 0;
        tick();
        check("drain_exit", state, RUN);
        dec_valid = 0; tick(); tick();
        wb_valid = 1; wb_dst = 7; tick(); wb_valid = 0;

        // Reset mid-operation, then stale writeback and unmatched writeback
        offer(op_add, 9, 0, 0); tick(); dec_valid = 0;
        do_reset();
        wb_valid = 1; wb_dst = 9; tick(); wb_valid = 0; tick();
        check("stale_wb_err", wb_err, 1);
        do_reset();
        wb_valid = 1; wb_dst = 7; tick(); wb_valid = 0; tick(); tick();
        check("wb_err_sticky", wb_err, 1);
        do_reset();

        // Random traffic
        for (int n = 0; n < N_RANDOM; n++) begin
            arstn     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            dec_valid = ($urandom_range(0, 9) < 7);
            dec_op    = alu_opcode_t'($urandom_range(0, 5));
            src1      = reg_t'($urandom_range(0, NUM_REGS - 1));
            src2      = reg_t'($urandom_range(0, NUM_REGS - 1));
            dst       = reg_t'($urandom_range(0, NUM_REGS - 1));
            ex_ready  = ($urandom_range(0, 3) != 0);
            q.delete();
            foreach (m_pend[i]) if (m_pend[i]) q.push_back(i);
            wb_valid  = 0;
            if ($urandom_range(0, 49) == 0) begin
                wb_valid = 1; wb_dst = reg_t'($urandom_range(0, NUM_REGS - 1));
            end else if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
                wb_valid = 1; wb_dst = reg_t'(q[$urandom_range(0, q.size() - 1)]);
            end
            tick();
        end

        idle(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
